vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 141 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, per-axis phase FSMs,
// registered sync, video window, coordinates and line/frame markers.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int CNT_W    = 10
) (
   input  logic             clkIn,
   input  logic             reset,
   input  logic             pixEn,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             line_end,
   output logic             frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   localparam logic [CNT_W-1:0] H_FP_S = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SY_S = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_BP_S = CNT_W'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [CNT_W-1:0] V_FP_S = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SY_S = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_BP_S = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_ACT = (SYNC_POL != 0);

   typedef enum logic [1:0] {
      ACTIVE,
      FRONT,
      SYNC,
      BACK
   } phase_t;

   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] vcnt;
   logic [CNT_W-1:0] hcnt_nxt;
   logic [CNT_W-1:0] vcnt_nxt;
   logic             hwrap;
   logic             vwrap;
   phase_t           hph;
   phase_t           hph_nxt;
   phase_t           vph;
   phase_t           vph_nxt;

   // Next counter values; vertical advances only on a horizontal wrap
   always_comb begin
      hwrap    = pixEn && (hcnt == H_LAST);
      vwrap    = hwrap && (vcnt == V_LAST);
      hcnt_nxt = hcnt;
      vcnt_nxt = vcnt;
      if (pixEn) begin
         if (hwrap) begin
            hcnt_nxt = '0;
         end else begin
            hcnt_nxt = hcnt + 1'b1;
         end
      end
      if (hwrap) begin
         if (vwrap) begin
            vcnt_nxt = '0;
         end else begin
            vcnt_nxt = vcnt + 1'b1;
         end
      end
   end

   always_comb begin
      hph_nxt = hph;
      if (pixEn) begin
         unique case (hph)
            ACTIVE: if (hcnt_nxt == H_FP_S) hph_nxt = FRONT;
            FRONT:  if (hcnt_nxt == H_SY_S) hph_nxt = SYNC;
            SYNC:   if (hcnt_nxt == H_BP_S) hph_nxt = BACK;
            BACK:   if (hcnt_nxt == '0)     hph_nxt = ACTIVE;
         endcase
      end
   end

   always_comb begin
      vph_nxt = vph;
      if (hwrap) begin
         unique case (vph)
            ACTIVE: if (vcnt_nxt == V_FP_S) vph_nxt = FRONT;
            FRONT:  if (vcnt_nxt == V_SY_S) vph_nxt = SYNC;
            SYNC:   if (vcnt_nxt == V_BP_S) vph_nxt = BACK;
            BACK:   if (vcnt_nxt == '0)     vph_nxt = ACTIVE;
         endcase
      end
   end

   always_ff @(posedge clkIn or posedge reset) begin
      if (reset) begin
         hcnt <= H_LAST;
         vcnt <= V_LAST;
         hph  <= BACK;
         vph  <= BACK;
      end else begin
         hcnt <= hcnt_nxt;
         vcnt <= vcnt_nxt;
         hph  <= hph_nxt;
         vph  <= vph_nxt;
      end
   end

   // Decode from next-state so outputs align with the new counters
   always_ff @(posedge clkIn or posedge reset) begin
      if (reset) begin
         hsync       <= ~SYNC_ACT;
         vsync       <= ~SYNC_ACT;
         video_on    <= 1'b0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (hph_nxt == SYNC) ? SYNC_ACT : ~SYNC_ACT;
         vsync       <= (vph_nxt == SYNC) ? SYNC_ACT : ~SYNC_ACT;
         video_on    <= (hph_nxt == ACTIVE) && (vph_nxt == ACTIVE);
         line_end    <= hwrap;
         frame_start <= vwrap;
      end
   end

   assign pixel_x = hcnt;
   assign pixel_y = vcnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size and shrunken-timing instances
// compared each cycle against a linear raster-position model.
module tb_vga_sync_gen;

   logic clkIn = 1'b0;
   logic reset;
   logic pixEnA;
   logic pixEnB;

   logic       hsA, vsA, vonA, leA, fsA;
   logic [9:0] pxA, pyA;
   logic       hsB, vsB, vonB, leB, fsB;
   logic [4:0] pxB, pyB;

   localparam int FA = 800 * 525;
   localparam int FB = 16 * 11;

   int compared   = 0;
   int mismatched = 0;

   int posA, posB;
   bit leEA, fsEA, leEB, fsEB;

   vga_sync_gen dutA (
      .clkIn(clkIn), .reset(reset), .pixEn(pixEnA),
      .hsync(hsA), .vsync(vsA), .video_on(vonA),
      .pixel_x(pxA), .pixel_y(pyA),
      .line_end(leA), .frame_start(fsA)
   );

   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(1), .CNT_W(5)
   ) dutB (
      .clkIn(clkIn), .reset(reset), .pixEn(pixEnB),
      .hsync(hsB), .vsync(vsB), .video_on(vonB),
      .pixel_x(pxB), .pixel_y(pyB),
      .line_end(leB), .frame_start(fsB)
   );

   always #5 clkIn = ~clkIn;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected outputs from a linear position within the frame
   task automatic chk_inst(
      input string n, input int pos,
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb,
      input bit pol,
      input logic hsO, input logic vsO, input logic vonO,
      input logic [31:0] pxO, input logic [31:0] pyO,
      input logic leO, input logic fsO, input bit leE, input bit fsE);
      int ht, x, y;
      bit hsE, vsE;
      ht  = ha + hf + hs + hb;
      x   = pos % ht;
      y   = pos / ht;
      hsE = (x >= ha + hf && x < ha + hf + hs) ? pol : !pol;
      vsE = (y >= va + vf && y < va + vf + vs) ? pol : !pol;
      chk({n, "_pixel_x"}, pxO, x);
      chk({n, "_pixel_y"}, pyO, y);
      chk({n, "_hsync"}, 32'(hsO), 32'(hsE));
      chk({n, "_vsync"}, 32'(vsO), 32'(vsE));
      chk({n, "_video_on"}, 32'(vonO), 32'((x < ha) && (y < va)));
      chk({n, "_line_end"}, 32'(leO), 32'(leE));
      chk({n, "_frame_start"}, 32'(fsO), 32'(fsE));
   endtask

   task automatic check_all();
      chk_inst("A", posA, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
               hsA, vsA, vonA, 32'(pxA), 32'(pyA), leA, fsA, leEA, fsEA);
      chk_inst("B", posB, 8, 2, 3, 3, 6, 1, 2, 2, 1'b1,
               hsB, vsB, vonB, 32'(pxB), 32'(pyB), leB, fsB, leEB, fsEB);
   endtask

   task automatic model_reset();
      posA = FA - 1;
      posB = FB - 1;
      leEA = 0; fsEA = 0;
      leEB = 0; fsEB = 0;
   endtask

   task automatic step(input bit enA, input bit enB);
      pixEnA = enA;
      pixEnB = enB;
      @(posedge clkIn);
      #1;
      leEA = enA && (posA % 800 == 799);
      fsEA = enA && (posA == FA - 1);
      if (enA) posA = (posA + 1) % FA;
      leEB = enB && (posB % 16 == 15);
      fsEB = enB && (posB == FB - 1);
      if (enB) posB = (posB + 1) % FB;
      check_all();
   endtask

   function automatic bit rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   initial begin
      reset  = 1'b1;
      pixEnA = 1'b0;
      pixEnB = 1'b0;
      model_reset();
      repeat (3) @(posedge clkIn);
      #1;
      check_all();
      chk("rst_px", 32'(pxA), 799);
      chk("rst_py", 32'(pyA), 524);
      reset = 1'b0;

      // Divider-like enable every 4th clock
      for (int i = 0; i < 48; i++) step(i % 4 == 3, i % 4 == 3);

      // Random enables past the first line, up to x = 300
      for (int i = 0; i < 1800; i++) step(rnd(), rnd());
      for (int i = 0; i < 2000 && posA % 800 != 300; i++)
         step(rnd(), rnd());
      chk("reach_x300", 32'(pxA), 300);

      // Frozen outputs with enable low
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
      chk("hold_x300", 32'(pxA), 300);

      // Continuous enable through a line wrap, stop at x = 400
      for (int i = 0; i < 1000; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 900 && posA % 800 != 400; i++)
         step(1'b1, 1'b1);
      chk("reach_x400", 32'(pxA), 400);

      // Asynchronous reset mid-frame
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clkIn);
      #1;
      check_all();
      reset = 1'b0;

      // Small instance, enable tied high over several frames
      for (int i = 0; i < 3 * FB + 7; i++) step(rnd(), 1'b1);
      for (int i = 0; i < 400; i++) step(rnd(), rnd());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
